// File: rtl/pipelined_adder.sv
// Chunked carry-pipelined adder/subtractor with valid/ready flow control.
// Each stage resolves CHUNK bits; the whole pipeline freezes while the output is back-pressured.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipelined_adder: CHUNK must divide WIDTH");
  end

  logic             w_stall;
  logic             w_v_q [STAGES];
  logic             w_c_q [STAGES];
  logic [WIDTH-1:0] w_a_q [STAGES];
  logic [WIDTH-1:0] w_b_q [STAGES];
  logic [WIDTH-1:0] w_s_q [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_v_in;
    logic             w_c_in;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_s_in;
    logic [WIDTH-1:0] w_s_nxt;
    logic [CHUNK:0]   w_chunk;
    logic             r_v;
    logic             r_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;

    // Subtraction is folded in at entry: B is inverted and the borrow-in becomes an inverted carry-in.
    if (k == 0) begin : g_head
      assign w_v_in = in_valid;
      assign w_a_in = A;
      assign w_b_in = Sub ? ~B : B;
      assign w_c_in = Sub ? ~Cin : Cin;
      assign w_s_in = '0;
    end else begin : g_body
      assign w_v_in = w_v_q[k-1];
      assign w_a_in = w_a_q[k-1];
      assign w_b_in = w_b_q[k-1];
      assign w_c_in = w_c_q[k-1];
      assign w_s_in = w_s_q[k-1];
    end

    assign w_chunk = {1'b0, w_a_in[k*CHUNK +: CHUNK]}
                   + {1'b0, w_b_in[k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, w_c_in};

    always_comb begin
      w_s_nxt = w_s_in;
      w_s_nxt[k*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
      end else if (!w_stall) begin
        r_v <= w_v_in;
        r_c <= w_chunk[CHUNK];
        r_a <= w_a_in;
        r_b <= w_b_in;
        r_s <= w_s_nxt;
      end
    end

    assign w_v_q[k] = r_v;
    assign w_c_q[k] = r_c;
    assign w_a_q[k] = r_a;
    assign w_b_q[k] = r_b;
    assign w_s_q[k] = r_s;
  end

  assign out_valid = w_v_q[STAGES-1];
  assign Sum       = w_s_q[STAGES-1];
  assign Cout      = w_c_q[STAGES-1];
  // Operand sign bits ride along to the last stage so overflow is judged on the effective B.
  assign Ovf       = (w_a_q[STAGES-1][WIDTH-1] == w_b_q[STAGES-1][WIDTH-1]) &&
                     (Sum[WIDTH-1] != w_a_q[STAGES-1][WIDTH-1]);

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4): directed table, stall, reset and random sweep.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        Sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovf;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  logic [17:0] q[$];
  logic        rst_nxt = 1'b1;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic su);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] r;
    logic        ov;
    bb = su ? ~b : b;
    c0 = su ? ~ci : ci;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
    ov = (a[15] == bb[15]) && (r[15] != a[15]);
    return {r[16], ov, r[15:0]};
  endfunction

  // One clock cycle: drive at the falling edge, sample 1ns later, score transfers due at the next rising edge.
  task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic su, input logic ordy, output logic acc);
    logic [17:0] exp;
    @(negedge clk);
    rst_n = rst_nxt;
    in_valid = iv; A = a; B = b; Cin = ci; Sub = su; out_ready = ordy;
    #1;
    acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_vs_stall", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (prev_stall)
        check("hold_while_stalled", {13'd0, out_valid, Cout, Ovf, Sum}, {13'd0, prev_out});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp = q.pop_front();
          check("sb_result", {14'd0, Cout, Ovf, Sum}, {14'd0, exp});
          pops++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(a, b, ci, su));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, Cout, Ovf, Sum};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[12];
    logic        acc;
    logic [15:0] ta[8];
    logic [15:0] tb_b[8];
    logic        tci[8];
    logic        tsu[8];
    int          n;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[8]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{16'h00F0, 16'h0010, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
    tbl[11] = '{16'h5000, 16'h3000, 1'b0, 1'b1, 16'h2000, 1'b1, 1'b0};

    // Reset state
    rst_nxt = 1'b0;
    repeat (3) cyc(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, acc);
    rst_nxt = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_sum", {16'd0, Sum}, 32'd0);
    check("reset_cout", {31'd0, Cout}, 32'd0);
    check("reset_ovf", {31'd0, Ovf}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed table: one transaction at a time, latency exactly 4
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, acc);
      check("table_accept", {31'd0, acc}, 32'd1);
      for (int d = 1; d <= 4; d++) begin
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        if (d < 4) check("table_latency_early", {31'd0, out_valid}, 32'd0);
      end
      check("table_out_valid", {31'd0, out_valid}, 32'd1);
      check("table_sum", {16'd0, Sum}, {16'd0, tbl[i].sum});
      check("table_cout", {31'd0, Cout}, {31'd0, tbl[i].cout});
      check("table_ovf", {31'd0, Ovf}, {31'd0, tbl[i].ovf});
    end

    // Back-to-back stream with a 3-cycle downstream stall in cycles 5..7
    for (int i = 0; i < 8; i++) begin
      ta[i]   = 16'($urandom);
      tb_b[i] = 16'($urandom);
      tci[i]  = 1'($urandom);
      tsu[i]  = 1'($urandom);
    end
    pops = 0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (n < 8) cyc(1'b1, ta[n], tb_b[n], tci[n], tsu[n], !(c >= 5 && c <= 7), acc);
      else       cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      if (acc) n++;
      if (c <= 12) check("stall_in_ready", {31'd0, in_ready}, {31'd0, !(c >= 5 && c <= 7)});
      if (c >= 5 && c <= 7) check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    check("stall_accepted", n, 32'd8);
    check("stall_delivered", pops, 32'd8);
    check("stall_queue_empty", q.size(), 32'd0);

    // Reset mid-flight discards three accepted transactions; input during reset is ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0, 1'b1, acc);
      check("rst_pre_accept", {31'd0, acc}, 32'd1);
    end
    rst_nxt = 1'b0;
    cyc(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b1, acc);
    rst_nxt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      check("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Random sweep with random in_valid / out_ready
    pops = 0;
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(3) != 0), acc);
      if (acc) n++;
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("sweep_queue_empty", q.size(), 32'd0);
    check("sweep_delivered", pops, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
